// File: rtl/frame_buffer_writer.sv
// Frame buffer write-port driver: clears the buffer after reset, then moves a one-pixel cursor with two debounced buttons.
// Define WRITER_TRAIL_EN to skip the erase step so visited pixels stay lit (trail mode).
module frame_buffer_writer #(
  parameter int              AW         = 8,
  parameter int              DW         = 3,
  parameter int              DEB_CYCLES = 750000,
  parameter logic [DW-1:0]   BG_COLOR   = 3'b000,
  parameter logic [DW-1:0]   FG_COLOR   = 3'b100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bntr,
  input  logic          bntl,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          busy,
  output logic [AW-1:0] cursor
);

  localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {CLEAR, PAINT, IDLE, ERASE} state_t;

`ifdef WRITER_TRAIL_EN
  localparam state_t MOVE_NEXT = PAINT;
`else
  localparam state_t MOVE_NEXT = ERASE;
`endif

  // index 0 = right button, index 1 = left button
  logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]         deb_q, deb_d, press_q, press_d;
  logic [1:0][CW-1:0] dcnt_q, dcnt_d;

  state_t             state_q, state_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [AW-1:0]      cursor_q, cursor_d, prev_q, prev_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      data_q, data_d;
  logic               we_q, we_d, busy_q, busy_d;

  // Button conditioning: synchronize, debounce, detect accepted rising edge.
  always_comb begin
    sync1_d = {bntl, bntr};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    dcnt_d  = dcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) begin
          deb_d[i]  = sync2_q[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + CW'(1);
        end
      end else begin
        dcnt_d[i] = '0;
      end
    end
    press_d = deb_d & ~deb_q;
  end

  // Writer FSM: next state and the registered write-port values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cursor_d = cursor_q;
    prev_d   = prev_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    busy_d   = (state_q != IDLE);
    case (state_q)
      CLEAR: begin
        addr_d = cnt_q[AW-1:0];
        data_d = BG_COLOR;
        we_d   = 1'b1;
        cnt_d  = cnt_q + (AW+1)'(1);
        if (cnt_d[AW]) begin
          state_d = PAINT;
        end else begin
          state_d = CLEAR;
        end
      end
      PAINT: begin
        addr_d  = cursor_q;
        data_d  = FG_COLOR;
        we_d    = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        if (press_q == 2'b01) begin
          prev_d   = cursor_q;
          cursor_d = cursor_q + AW'(1);
          state_d  = MOVE_NEXT;
        end else if (press_q == 2'b10) begin
          prev_d   = cursor_q;
          cursor_d = cursor_q - AW'(1);
          state_d  = MOVE_NEXT;
        end else begin
          state_d = IDLE;
        end
      end
      ERASE: begin
        addr_d  = prev_q;
        data_d  = BG_COLOR;
        we_d    = 1'b1;
        state_d = PAINT;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      deb_q    <= 2'b00;
      dcnt_q   <= '0;
      press_q  <= 2'b00;
      state_q  <= CLEAR;
      cnt_q    <= '0;
      cursor_q <= '0;
      prev_q   <= '0;
      addr_q   <= '0;
      data_q   <= BG_COLOR;
      we_q     <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      dcnt_q   <= dcnt_d;
      press_q  <= press_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cursor_q <= cursor_d;
      prev_q   <= prev_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
    end
  end

  assign addr_in  = addr_q;
  assign data_in  = data_q;
  assign regwrite = we_q;
  assign busy     = busy_q;
  assign cursor   = cursor_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed self-checking bench for frame_buffer_writer (AW=8, DEB_CYCLES=4); expectations follow WRITER_TRAIL_EN.
module tb_frame_buffer_writer;

  localparam int         AW  = 8;
  localparam int         DW  = 3;
  localparam int         DEB = 4;
  localparam logic [2:0] BG  = 3'b000;
  localparam logic [2:0] FG  = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bntr = 1'b0;
  logic          bntl = 1'b0;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;
  logic          busy;
  logic [AW-1:0] cursor;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } wr_t;
  wr_t wq[$];
  wr_t wrec;

  typedef struct {
    logic          r;
    logic          l;
    int            hold;
    int            nw;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [AW-1:0] cur;
  } vec_t;
  vec_t tv[7];

  frame_buffer_writer #(
    .AW(AW), .DW(DW), .DEB_CYCLES(DEB), .BG_COLOR(BG), .FG_COLOR(FG)
  ) dut (
    .clk(clk), .rst(rst), .bntr(bntr), .bntl(bntl),
    .addr_in(addr_in), .data_in(data_in), .regwrite(regwrite),
    .busy(busy), .cursor(cursor)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every write seen on the buffer port
  always @(negedge clk) begin
    if (regwrite) begin
      wrec.a = addr_in;
      wrec.d = data_in;
      wrec.c = cyc;
      wq.push_back(wrec);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy && !regwrite) done = 1'b1;
    end
    chk({name, "_idle_timeout"}, int'(done), 1);
  endtask

  initial begin
    // move table: {r, l, hold, nw, a0, d0, a1, d1, cursor after}
    tv[0] = '{1'b1, 1'b0, 10, 2, 8'd0,   BG, 8'd1,   FG, 8'd1};
    tv[1] = '{1'b0, 1'b1, 10, 2, 8'd1,   BG, 8'd0,   FG, 8'd0};
    tv[2] = '{1'b0, 1'b1, 10, 2, 8'd0,   BG, 8'd255, FG, 8'd255};
    tv[3] = '{1'b1, 1'b0, 10, 2, 8'd255, BG, 8'd0,   FG, 8'd0};
    tv[4] = '{1'b1, 1'b1, 10, 0, 8'd0,   BG, 8'd0,   FG, 8'd0};
    tv[5] = '{1'b1, 1'b0, 2,  0, 8'd0,   BG, 8'd0,   FG, 8'd0};
    tv[6] = '{1'b1, 1'b0, 10, 2, 8'd0,   BG, 8'd1,   FG, 8'd1};

    // reset values
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", int'(addr_in), 0);
    chk("rst_data", int'(data_in), int'(BG));
    chk("rst_we", int'(regwrite), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_cursor", int'(cursor), 0);

    // full clear, first paint, then idle at edge 258
    rst = 1'b1;
    for (int k = 1; k <= 258; k++) begin
      @(negedge clk);
      if (k <= 256) begin
        chk("clr_we", int'(regwrite), 1);
        chk("clr_addr", int'(addr_in), k - 1);
        chk("clr_data", int'(data_in), int'(BG));
        chk("clr_busy", int'(busy), 1);
      end else if (k == 257) begin
        chk("paint0_we", int'(regwrite), 1);
        chk("paint0_addr", int'(addr_in), 0);
        chk("paint0_data", int'(data_in), int'(FG));
      end else begin
        chk("idle_we", int'(regwrite), 0);
        chk("idle_busy", int'(busy), 0);
      end
    end
    repeat (5) @(negedge clk);

    // table-driven moves
    for (int i = 0; i < 7; i++) begin
`ifdef WRITER_TRAIL_EN
      if (tv[i].nw == 2) begin
        tv[i].nw = 1;
        tv[i].a0 = tv[i].a1;
        tv[i].d0 = tv[i].d1;
      end
`endif
      wq.delete();
      bntr = tv[i].r;
      bntl = tv[i].l;
      repeat (tv[i].hold) @(negedge clk);
      bntr = 1'b0;
      bntl = 1'b0;
      repeat (30) @(negedge clk);
      chk($sformatf("v%0d_nwrites", i), wq.size(), tv[i].nw);
      if (wq.size() >= 1 && tv[i].nw >= 1) begin
        chk($sformatf("v%0d_w0_addr", i), int'(wq[0].a), int'(tv[i].a0));
        chk($sformatf("v%0d_w0_data", i), int'(wq[0].d), int'(tv[i].d0));
      end
      if (wq.size() >= 2 && tv[i].nw >= 2) begin
        chk($sformatf("v%0d_w1_addr", i), int'(wq[1].a), int'(tv[i].a1));
        chk($sformatf("v%0d_w1_data", i), int'(wq[1].d), int'(tv[i].d1));
        chk($sformatf("v%0d_w1_back2back", i), wq[1].c - wq[0].c, 1);
      end
      chk($sformatf("v%0d_cursor", i), int'(cursor), int'(tv[i].cur));
      chk($sformatf("v%0d_busy", i), int'(busy), 0);
    end

    // press during clear is dropped
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    bntr = 1'b1;
    repeat (10) @(negedge clk);
    bntr = 1'b0;
    wait_idle("clrpress");
    chk("clrpress_cursor", int'(cursor), 0);
    wq.delete();
    repeat (20) @(negedge clk);
    chk("clrpress_nowrite", wq.size(), 0);

    // reset at clear address 100 restarts from address 0
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
        @(negedge clk);
        if (regwrite && addr_in == 8'd100) hit = 1'b1;
      end
      chk("midrst_reach100", int'(hit), 1);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_we", int'(regwrite), 0);
    chk("midrst_addr", int'(addr_in), 0);
    chk("midrst_busy", int'(busy), 1);
    rst = 1'b1;
    wq.delete();
    @(negedge clk);
    chk("restart_we", int'(regwrite), 1);
    chk("restart_addr", int'(addr_in), 0);
    wait_idle("restart");
    chk("restart_nwrites", wq.size(), 257);
    chk("restart_cursor", int'(cursor), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_buffer_writer.md
# frame_buffer_writer

Upstream writer for the dual-port frame buffer: drives the buffer's write port (address, data, write enable) from the two board buttons. After reset it clears the whole buffer to a background colour, then keeps a single foreground "cursor" pixel that the right/left buttons move through the buffer. It shares the 75 MHz pixel clock with the buffer and the 1024x768 VGA driver.

## Interface

- AW, 8, buffer address width; buffer depth is 2^AW
- DW, 3, pixel width (RGB 111)
- DEB_CYCLES, 750000, cycles a synchronized button must hold a new level before it is accepted (10 ms at 75 MHz)
- BG_COLOR, 3'b000, colour written by clear and erase
- FG_COLOR, 3'b100, cursor colour

- clk  in  1  pixel clock (clk75M); all logic on rising edge
- rst  in  1  synchronous, active-low reset (same board button as the VGA driver)
- bntr  in  1  raw button, asynchronous, active-high; moves cursor +1
- bntl  in  1  raw button, asynchronous, active-high; moves cursor −1
- addr_in  out  AW  buffer write address, registered
- data_in  out  DW  buffer write data, registered
- regwrite  out  1  buffer write enable, registered, one write per high cycle
- busy  out  1  high in CLEAR, ERASE, PAINT
- cursor  out  AW  current cursor address

## Operation

- Input conditioning per button: 2-FF synchronizer → debouncer → rising-edge detector. Accepted level changes only after the synchronized input has differed from it for DEB_CYCLES consecutive cycles; any agreeing sample restarts the count. A press is one cycle pulse on an accepted 0→1 transition.
- States: CLEAR, PAINT, IDLE, ERASE.
  - CLEAR: write BG_COLOR to addresses 0 … 2^AW−1, one per cycle, ascending; after the last address → PAINT.
  - PAINT: one write of FG_COLOR at cursor → IDLE.
  - IDLE: regwrite=0. Press on bntr only: cursor ← cursor+1 (mod 2^AW), → ERASE. Press on bntl only: cursor ← cursor−1 (mod 2^AW), → ERASE. Both presses in the same cycle: ignored, stay IDLE.
  - ERASE: one write of BG_COLOR at the previous cursor → PAINT.
- Presses arriving outside IDLE are discarded, not queued. The debouncers keep running in every state.
- Wrap-around: 2^AW−1 + 1 → 0; 0 − 1 → 2^AW−1.
- Address arithmetic is AW-bit unsigned with natural overflow. The CLEAR counter is AW+1 bits so the terminal condition is detected without aliasing.

## Timing

- While rst=0, on every edge:
  - state=CLEAR, clear counter=0, cursor=0
  - addr_in=0, data_in=BG_COLOR, regwrite=0, busy=1
  - synchronizers, debounce levels and counters = 0
- Edge 1 after rst goes high: addr_in=0, data_in=BG_COLOR, regwrite=1.
- Edge k (k=1…2^AW): addr_in=k−1. Edge 2^AW+1: PAINT write (addr 0, FG_COLOR). Edge 2^AW+2: regwrite=0, busy=0.
- A press detected in IDLE at edge N:
  - N+1: ERASE write (old cursor, BG_COLOR). The cursor output already shows the new value.
  - N+2: PAINT write (new cursor, FG_COLOR).
  - N+3: IDLE, regwrite=0.
- Raw-button to press latency: 2 (sync) + DEB_CYCLES + 1 (edge) cycles.
- Reset asserted mid-operation: takes effect on the next edge and restarts from CLEAR. Any partial clear is simply redone.

## Configuration

- WRITER_TRAIL_EN defined: ERASE is never entered. A move goes IDLE → PAINT → IDLE (write at N+1, idle at N+2), so visited pixels stay FG_COLOR and draw a trail.
- Undefined: single-pixel cursor with ERASE as specified above.

## Test plan

- All tests use AW=8, DEB_CYCLES=4.
- Reset release → exactly 256 consecutive writes, addr 0…255, data 3'b000, then one write addr 0 data 3'b100, then regwrite=0 and busy=0 at edge 258.
- bntr held high 10 cycles in IDLE → one ERASE (addr 0, 3'b000), then PAINT (addr 1, 3'b100); cursor=1.
- bntl pressed with cursor=0 → ERASE addr 0, PAINT addr 255; cursor=255. From cursor=255, bntr → cursor=0.
- bntr toggling with 2-cycle pulses → no press accepted, regwrite stays 0. bntr and bntl accepted in the same cycle → no write, cursor unchanged.
- Press during CLEAR is dropped (cursor still 0 at IDLE entry). rst pulled low at clear address 100 → restart from addr 0.
- With WRITER_TRAIL_EN: three bntr presses → writes to addr 1, 2, 3 with data 3'b100 only, no BG writes.
